bcast_scheduler: RTL and testbench

Round-robin scheduler that shares the 1-to-16 multibroadcasting network between N requesters. Each requester presents a data bit and a network configuration (pb routing bits, lb level bits). The block grants one requester at a time and sequences the transfer as apply config, settle, drive data, capture the 16-bit network output. It then returns the network to an all-zero idle configuration.

---
 rtl/bcast_scheduler.sv | 172 +++++++++++++++++
 tb/tb_bcast_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcast_scheduler.sv
// Round-robin arbiter sharing one 1-to-16 broadcast network among N requesters; BCAST_SCHED_STAT_EN adds per-requester done counters.
// Latency: grant one cycle after req is sampled; done after SETUP_CYCLES+HOLD_CYCLES+1 cycles; at least one idle cycle between transfers.
// Backpressure: requester holds req until done; dropping req during SETUP/DRIVE abandons the transfer.
module bcast_scheduler #(
    parameter int N            = 4,
    parameter int SETUP_CYCLES = 1,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   req_data,
    input  logic [4*N-1:0] req_pb,
    input  logic [2*N-1:0] req_lb,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic           net_inp,
    output logic [3:0]     net_pb,
    output logic [1:0]     net_lb,
    input  logic [15:0]    net_w,
    output logic [15:0]    cap_w,
`ifdef BCAST_SCHED_STAT_EN
    output logic [8*N-1:0] grant_cnt,
`endif
    output logic           busy
);

    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam int MAXC = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, DRIVE, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   win_q, win_d;
    logic            data_q, data_d;
    logic [3:0]      pb_q, pb_d;
    logic [1:0]      lb_q, lb_d;
    logic [15:0]     cap_w_q, cap_w_d;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            win_q   <= '0;
            data_q  <= 1'b0;
            pb_q    <= '0;
            lb_q    <= '0;
            cap_w_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            data_q  <= data_d;
            pb_q    <= pb_d;
            lb_q    <= lb_d;
            cap_w_q <= cap_w_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        win_d   = win_q;
        data_d  = data_q;
        pb_d    = pb_q;
        lb_d    = lb_q;
        cap_w_d = cap_w_q;
        found   = 1'b0;
        pick    = rr_q;
        idx     = '0;

        // First pending requester at or after the rr pointer, wrapping.
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(rr_q) + i) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    win_d   = pick;
                    rr_d    = (pick == IW'(N - 1)) ? '0 : pick + IW'(1);
                    for (int i = 0; i < N; i++) begin
                        if (IW'(i) == pick) begin
                            data_d = req_data[i];
                            pb_d   = req_pb[4*i +: 4];
                            lb_d   = req_lb[2*i +: 2];
                        end
                    end
                end
            end
            SETUP: begin
                if (!req[win_q]) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRIVE: begin
                if (!req[win_q]) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    cap_w_d = net_w;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registered state only, so reset clears them immediately.
    always_comb begin
        grant   = '0;
        done    = '0;
        net_inp = 1'b0;
        net_pb  = '0;
        net_lb  = '0;
        busy    = (state_q != IDLE);
        cap_w   = cap_w_q;
        if (state_q != IDLE) grant = N'(1) << win_q;
        if (state_q == RELEASE) done = N'(1) << win_q;
        if (state_q == SETUP || state_q == DRIVE) begin
            net_pb = pb_q;
            net_lb = lb_q;
        end
        if (state_q == DRIVE) net_inp = data_q;
    end

`ifdef BCAST_SCHED_STAT_EN
    logic [7:0] stat_q [N];
    logic [7:0] stat_d [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) stat_q[i] <= stat_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            stat_d[i] = stat_q[i];
            if (state_q == RELEASE && IW'(i) == win_q && stat_q[i] != 8'hFF)
                stat_d[i] = stat_q[i] + 8'd1;
            grant_cnt[8*i +: 8] = stat_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_bcast_scheduler.sv
// Directed, table-driven bench for bcast_scheduler at default parameters.
module tb_bcast_scheduler;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   req_data;
    logic [4*N-1:0] req_pb;
    logic [2*N-1:0] req_lb;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           net_inp;
    logic [3:0]     net_pb;
    logic [1:0]     net_lb;
    logic [15:0]    net_w;
    logic [15:0]    cap_w;
    logic           busy;
`ifdef BCAST_SCHED_STAT_EN
    logic [8*N-1:0] grant_cnt;
`endif

    bcast_scheduler #(.N(N), .SETUP_CYCLES(1), .HOLD_CYCLES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_pb   (req_pb),
        .req_lb   (req_lb),
        .grant    (grant),
        .done     (done),
        .net_inp  (net_inp),
        .net_pb   (net_pb),
        .net_lb   (net_lb),
        .net_w    (net_w),
        .cap_w    (cap_w),
`ifdef BCAST_SCHED_STAT_EN
        .grant_cnt(grant_cnt),
`endif
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [3:0] done;
        logic       inp;
        logic [3:0] pb;
        logic [1:0] lb;
        logic       busy;
    } vec_t;

    vec_t tab [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string name, input logic [3:0] g, input logic [3:0] d,
                            input logic inp, input logic [3:0] pb, input logic [1:0] lb,
                            input logic b);
        chk({name, ".grant"}, 32'(grant), 32'(g));
        chk({name, ".done"}, 32'(done), 32'(d));
        chk({name, ".net_inp"}, 32'(net_inp), 32'(inp));
        chk({name, ".net_pb"}, 32'(net_pb), 32'(pb));
        chk({name, ".net_lb"}, 32'(net_lb), 32'(lb));
        chk({name, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        tab[0] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b1000, 2'b01, 1'b1};
        tab[1] = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b1000, 2'b01, 1'b1};
        tab[2] = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b1000, 2'b01, 1'b1};
        tab[3] = '{4'b0100, 4'b0100, 4'b0100, 1'b0, 4'b0000, 2'b00, 1'b1};
        tab[4] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0};
        tab[5] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0};

        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        req_pb   = '0;
        req_lb   = '0;
        net_w    = '0;
        #1;
        chk_outs("reset", 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0);
        chk("reset.cap_w", 32'(cap_w), 32'h0);
`ifdef BCAST_SCHED_STAT_EN
        chk("reset.grant_cnt", grant_cnt, 32'h0);
`endif
        #2;
        rst = 1'b0;
        step();

        // Single request from requester 2, vectors applied cycle by cycle.
        req_data[2]   = 1'b1;
        req_pb[11:8]  = 4'b1000;
        req_lb[5:4]   = 2'b01;
        net_w         = 16'hA5C3;
        for (int i = 0; i < 6; i++) begin
            req = tab[i].req;
            step();
            chk_outs($sformatf("single[%0d]", i), tab[i].grant, tab[i].done,
                     tab[i].inp, tab[i].pb, tab[i].lb, tab[i].busy);
            if (i == 3) chk("single.cap_w", 32'(cap_w), 32'hA5C3);
        end
        req_data = '0;
        req_pb   = '0;
        req_lb   = '0;

        // Input stability: requester 1 inputs change after grant.
        req_data[1]  = 1'b1;
        req_pb[7:4]  = 4'b0110;
        req_lb[3:2]  = 2'b10;
        req          = 4'b0010;
        step();
        chk_outs("stable.setup", 4'b0010, 4'b0000, 1'b0, 4'b0110, 2'b10, 1'b1);
        req_data[1] = 1'b0;
        req_pb[7:4] = 4'b1001;
        req_lb[3:2] = 2'b01;
        step();
        chk_outs("stable.drive", 4'b0010, 4'b0000, 1'b1, 4'b0110, 2'b10, 1'b1);

        // Asynchronous reset between edges while in DRIVE.
        #2;
        rst = 1'b1;
        #1;
        chk_outs("async_rst", 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0);
        chk("async_rst.cap_w", 32'(cap_w), 32'h0);
        #1;
        rst = 1'b0;
        req_data = '0;
        req_pb   = '0;
        req_lb   = '0;

        // rr restarted at 0: requester 1 wins over 3 (rr=2 would pick 3).
        req = 4'b1010;
        step();
        chk("rr_after_rst.grant", 32'(grant), 32'b0010);
        req = 4'b1000;
        step();
        chk_outs("abandon_setup", 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0);
        step();
        chk("req3_alone.grant", 32'(grant), 32'b1000);
        req = 4'b0000;
        step();
        chk("req3_drop.busy", 32'(busy), 32'h0);

        // All four requesting continuously: strict round-robin, 4 busy + 1 idle each.
        do_reset();
        for (int t = 0; t < 25; t++) begin
            int k;
            int w;
            int ph;
            k  = t / 5;
            ph = t % 5;
            w  = (k % 4);
            req   = 4'b1111;
            net_w = 16'(16'h1111 * (k + 1));
            step();
            chk($sformatf("rr[%0d].grant", t), 32'(grant), (ph < 4) ? (32'h1 << w) : 32'h0);
            chk($sformatf("rr[%0d].done", t), 32'(done), (ph == 3) ? (32'h1 << w) : 32'h0);
            if (ph == 3) chk($sformatf("rr[%0d].cap_w", t), 32'(cap_w), 32'(16'h1111 * (k + 1)));
        end
        req = 4'b0000;

        // Abandon during DRIVE; rr currently 1, requester 2 pending behind 1.
        net_w = 16'hFFFF;
        req   = 4'b0110;
        step();
        chk("abandon.grant1", 32'(grant), 32'b0010);
        step();
        chk("abandon.in_drive", 32'(net_inp), 32'h0);
        req = 4'b0100;
        step();
        chk_outs("abandon.idle", 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0);
        chk("abandon.cap_w", 32'(cap_w), 32'h5555);
        step();
        chk("abandon.next_grant", 32'(grant), 32'b0100);
        req = 4'b0000;
        step();
        step();

`ifdef BCAST_SCHED_STAT_EN
        do_reset();
        req = 4'b0001;
        for (int t = 0; t < 5; t++) step();
        chk("stat.one", grant_cnt, 32'h1);
        for (int t = 5; t < 1500; t++) step();
        req = 4'b0000;
        step();
        step();
        chk("stat.sat0", 32'(grant_cnt[7:0]), 32'd255);
        chk("stat.others", 32'(grant_cnt[31:8]), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
